// File: rtl/trace_plotter_if.sv
// Pixel write port between the trace plotter and the VGA frame-buffer arbiter.
// A write is presented on wr_req/wr_x/wr_y/wr_data and completes on the
// rising clock edge where wr_ack is sampled high.
interface trace_plotter_if;
  logic       wr_req;
  logic [9:0] wr_x;
  logic [8:0] wr_y;
  logic [7:0] wr_data;
  logic       wr_ack;

  modport master (output wr_req, wr_x, wr_y, wr_data, input wr_ack);
  modport slave  (input wr_req, wr_x, wr_y, wr_data, output wr_ack);
endinterface

// File: rtl/trace_plotter.sv
// Scrolling dual-trace plotter: decimates the integrator position stream,
// maps x1/x2 to screen rows, and for each kept sample erases one VGA column,
// plots both traces into it and advances to the next column.
module trace_plotter #(
  parameter int          H_RES      = 640,
  parameter int          V_RES      = 480,
  parameter int          DECIM      = 64,
  parameter int          SCALE_LOG2 = 7,
  parameter int          Y1_CENTER  = 120,
  parameter int          Y2_CENTER  = 360,
  parameter logic [7:0]  COLOR1     = 8'hE0,
  parameter logic [7:0]  COLOR2     = 8'h1C,
  parameter logic [7:0]  BG         = 8'h00
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic signed [17:0]  x1,
  input  logic signed [17:0]  x2,
  trace_plotter_if.master     wr,
  output logic [9:0]          vga_xCoord,
  output logic                busy,
  output logic                overrun,
  output logic                frame_wrap
);

  localparam int unsigned        SHIFT = 16 - SCALE_LOG2;
  localparam int                 DCW   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DCW-1:0]     DLAST = DCW'(DECIM - 1);
  localparam logic [9:0]         XLAST = 10'(H_RES - 1);
  localparam logic [8:0]         YLAST = 9'(V_RES - 1);
  localparam logic signed [19:0] YMAX  = 20'(V_RES - 1);
  localparam logic signed [19:0] C1    = 20'(Y1_CENTER);
  localparam logic signed [19:0] C2    = 20'(Y2_CENTER);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_PLOT1,
    S_PLOT2,
    S_ADVANCE
  } state_e;

  state_e           state_q, state_d;
  logic [DCW-1:0]   dcnt_q, dcnt_d;
  logic [8:0]       y1_q, y1_d;
  logic [8:0]       y2_q, y2_d;
  logic             wr_req_q, wr_req_d;
  logic [9:0]       wr_x_q, wr_x_d;
  logic [8:0]       wr_y_q, wr_y_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic [9:0]       xcoord_q, xcoord_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic             frame_wrap_q, frame_wrap_d;
  logic             keep;
  logic             accept;

  // Scale a 2.16 position to a screen row around the trace centre, clamped
  // to the visible rows.
  function automatic logic [8:0] map_row(input logic signed [17:0] x,
                                         input logic signed [19:0] center);
    logic signed [19:0] xe;
    logic signed [19:0] off;
    logic signed [19:0] y;
    xe  = {{2{x[17]}}, x};
    off = xe >>> SHIFT;
    y   = center - off;
    if (y[19])         map_row = '0;
    else if (y > YMAX) map_row = YLAST;
    else               map_row = y[8:0];
  endfunction

  // Next-state logic: decimation, capture, column write sequencing.
  always_comb begin
    state_d      = state_q;
    dcnt_d       = dcnt_q;
    y1_d         = y1_q;
    y2_d         = y2_q;
    wr_req_d     = wr_req_q;
    wr_x_d       = wr_x_q;
    wr_y_d       = wr_y_q;
    wr_data_d    = wr_data_q;
    xcoord_d     = xcoord_q;
    overrun_d    = overrun_q;
    frame_wrap_d = 1'b0;

    keep = sample_valid && (dcnt_q == DLAST);
    // ADVANCE is about to return to IDLE, so a sample landing there is
    // taken as if the block were already idle.
    accept = keep && ((state_q == S_IDLE) || (state_q == S_ADVANCE));

    if (sample_valid) begin
      if (keep) dcnt_d = '0;
      else      dcnt_d = dcnt_q + 1'b1;
    end
    if (keep && !accept) overrun_d = 1'b1;

    case (state_q)
      S_CLEAR: begin
        if (wr.wr_ack) begin
          if (wr_y_q == YLAST) begin
            state_d   = S_PLOT1;
            wr_y_d    = y1_q;
            wr_data_d = COLOR1;
          end else begin
            wr_y_d = wr_y_q + 1'b1;
          end
        end
      end
      S_PLOT1: begin
        if (wr.wr_ack) begin
          state_d   = S_PLOT2;
          wr_y_d    = y2_q;
          wr_data_d = COLOR2;
        end
      end
      S_PLOT2: begin
        if (wr.wr_ack) begin
          state_d  = S_ADVANCE;
          wr_req_d = 1'b0;
        end
      end
      S_ADVANCE: begin
        state_d = S_IDLE;
        if (xcoord_q == XLAST) begin
          xcoord_d     = '0;
          frame_wrap_d = 1'b1;
        end else begin
          xcoord_d = xcoord_q + 1'b1;
        end
      end
      default: ;
    endcase

    if (accept) begin
      state_d   = S_CLEAR;
      y1_d      = map_row(x1, C1);
      y2_d      = map_row(x2, C2);
      wr_req_d  = 1'b1;
      wr_x_d    = xcoord_d;
      wr_y_d    = '0;
      wr_data_d = BG;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs, asynchronously cleared.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      dcnt_q       <= '0;
      y1_q         <= '0;
      y2_q         <= '0;
      wr_req_q     <= 1'b0;
      wr_x_q       <= '0;
      wr_y_q       <= '0;
      wr_data_q    <= '0;
      xcoord_q     <= '0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      frame_wrap_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dcnt_q       <= dcnt_d;
      y1_q         <= y1_d;
      y2_q         <= y2_d;
      wr_req_q     <= wr_req_d;
      wr_x_q       <= wr_x_d;
      wr_y_q       <= wr_y_d;
      wr_data_q    <= wr_data_d;
      xcoord_q     <= xcoord_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      frame_wrap_q <= frame_wrap_d;
    end
  end

  assign wr.wr_req   = wr_req_q;
  assign wr.wr_x     = wr_x_q;
  assign wr.wr_y     = wr_y_q;
  assign wr.wr_data  = wr_data_q;
  assign vga_xCoord  = xcoord_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign frame_wrap  = frame_wrap_q;

endmodule

// File: tb/tb_trace_plotter.sv
// Bench for trace_plotter: full-size instance (DECIM=1) for column content,
// latency, stall and reset; short-column instance (DECIM=4, V_RES=16) for
// decimation, overrun, back-to-back capture and frame wrap.
module tb_trace_plotter;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        sv_a  = 1'b0;
  logic        sv_b  = 1'b0;
  logic        ack_a = 1'b1;
  logic        ack_b = 1'b1;
  logic [17:0] x1    = '0;
  logic [17:0] x2    = '0;
  logic [9:0]  vx_a, vx_b;
  logic        busy_a, busy_b, ovr_a, ovr_b, fw_a, fw_b;

  int checks   = 0;
  int failures = 0;

  trace_plotter_if a_if ();
  trace_plotter_if b_if ();
  assign a_if.wr_ack = ack_a;
  assign b_if.wr_ack = ack_b;

  always #5 clk = ~clk;

  trace_plotter #(.DECIM(1)) dut_a (
    .CLOCK_50(clk), .reset(rst_n), .sample_valid(sv_a), .x1(x1), .x2(x2),
    .wr(a_if), .vga_xCoord(vx_a), .busy(busy_a), .overrun(ovr_a), .frame_wrap(fw_a));

  trace_plotter #(.DECIM(4), .V_RES(16)) dut_b (
    .CLOCK_50(clk), .reset(rst_n), .sample_valid(sv_b), .x1(x1), .x2(x2),
    .wr(b_if), .vga_xCoord(vx_b), .busy(busy_b), .overrun(ovr_b), .frame_wrap(fw_b));

  typedef struct {
    logic [17:0] vx1;
    logic [17:0] vx2;
    int          ey1;
    int          ey2;
    string       nm;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // One kept sample on dut_a, then follow the column to IDLE.
  task automatic run_col(input logic [17:0] vx1, input logic [17:0] vx2,
                         input int ey1, input int ey2, input int col,
                         input bit rnd, input string nm);
    int nwr = 0;
    int bad = 0;
    int stab_bad = 0;
    int stalls = 0;
    int edges = -1;
    bit prev_pend = 0;
    logic [9:0] px;
    logic [8:0] py;
    logic [7:0] pd;
    int ey;
    logic [7:0] ed;
    @(negedge clk);
    x1 = vx1; x2 = vx2; sv_a = 1'b1; ack_a = 1'b1;
    @(negedge clk);
    sv_a = 1'b0;
    check({nm, " start_busy"}, busy_a, 1);
    check({nm, " start_req"}, a_if.wr_req, 1);
    check({nm, " start_y"}, a_if.wr_y, 0);
    check({nm, " start_x"}, a_if.wr_x, col);
    for (int k = 1; k <= 4000; k++) begin
      if (!busy_a) begin
        edges = k - 1;
        break;
      end
      if (prev_pend && (a_if.wr_req !== 1'b1 || a_if.wr_x !== px ||
                        a_if.wr_y !== py || a_if.wr_data !== pd))
        stab_bad++;
      ack_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (a_if.wr_req === 1'b1) begin
        if (ack_a) begin
          if (nwr < 480)       begin ey = nwr; ed = 8'h00; end
          else if (nwr == 480) begin ey = ey1; ed = 8'hE0; end
          else if (nwr == 481) begin ey = ey2; ed = 8'h1C; end
          else                 begin ey = -1;  ed = 8'hxx; end
          if (a_if.wr_x !== 10'(col) || ey < 0 || a_if.wr_y !== 9'(ey) ||
              a_if.wr_data !== ed) begin
            if (bad == 0)
              $display("  first bad write #%0d: x=%0d y=%0d d=%h", nwr,
                       a_if.wr_x, a_if.wr_y, a_if.wr_data);
            bad++;
          end
          nwr++;
          prev_pend = 0;
        end else begin
          stalls++;
          prev_pend = 1;
          px = a_if.wr_x; py = a_if.wr_y; pd = a_if.wr_data;
        end
      end else begin
        prev_pend = 0;
      end
      @(negedge clk);
    end
    ack_a = 1'b1;
    check({nm, " busy_fall_edge"}, edges, 483 + stalls);
    check({nm, " write_count"}, nwr, 482);
    check({nm, " bad_writes"}, bad, 0);
    check({nm, " stable_violations"}, stab_bad, 0);
    check({nm, " xcoord_next"}, vx_a, col + 1);
  endtask

  initial begin
    int col;
    int wraps;
    int wrap_col;
    int to_bad;
    logic [9:0] vx_pre;

    vecs[0] = '{18'h38000, 18'h08000, 184, 296, "half"};
    vecs[1] = '{18'h1FFFF, 18'h20000,   0, 479, "clamp"};
    vecs[2] = '{18'h00000, 18'h00000, 120, 360, "zero"};
    vecs[3] = '{18'h00000, 18'h1E000, 120, 120, "equal"};
    vecs[4] = '{18'h00100, 18'h3FFFF, 120, 361, "tiny"};
    vecs[5] = '{18'h0F000, 18'h31200,   0, 479, "edge"};

    // asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #1;
    check("rst wr_req", a_if.wr_req, 0);
    check("rst wr_x", a_if.wr_x, 0);
    check("rst wr_y", a_if.wr_y, 0);
    check("rst wr_data", a_if.wr_data, 0);
    check("rst xcoord", vx_a, 0);
    check("rst busy", busy_a, 0);
    check("rst overrun", ovr_a, 0);
    check("rst frame_wrap", fw_a, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    col = 0;
    for (int i = 0; i < 6; i++) begin
      run_col(vecs[i].vx1, vecs[i].vx2, vecs[i].ey1, vecs[i].ey2, col, 1'b0, vecs[i].nm);
      col++;
    end
    run_col(vecs[0].vx1, vecs[0].vx2, vecs[0].ey1, vecs[0].ey2, col, 1'b1, "stall");
    col++;
    check("no overrun a", ovr_a, 0);

    // reset in the middle of CLEAR
    @(negedge clk);
    x1 = vecs[0].vx1; x2 = vecs[0].vx2; sv_a = 1'b1;
    @(negedge clk);
    sv_a = 1'b0;
    for (int t = 0; t < 1000 && !(a_if.wr_req === 1'b1 && a_if.wr_y == 9'd200); t++)
      @(negedge clk);
    check("midrst row", a_if.wr_y, 200);
    check("midrst xcoord_before", vx_a, col);
    #2 rst_n = 1'b0;
    #1;
    check("midrst wr_req", a_if.wr_req, 0);
    check("midrst busy", busy_a, 0);
    check("midrst xcoord", vx_a, 0);
    check("midrst wr_y", a_if.wr_y, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_col(vecs[0].vx1, vecs[0].vx2, vecs[0].ey1, vecs[0].ey2, 0, 1'b0, "post_rst");

    // decimation and overrun: sample every cycle, columns of 19 cycles
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    sv_b = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      check($sformatf("decim busy k=%0d", k), busy_b,
            ((k >= 4 && k <= 22) || (k >= 24 && k <= 42) || k >= 44) ? 1 : 0);
      check($sformatf("decim overrun k=%0d", k), ovr_b, (k >= 8) ? 1 : 0);
      check($sformatf("decim xcoord k=%0d", k), vx_b, (k >= 43) ? 2 : ((k >= 23) ? 1 : 0));
    end
    sv_b = 1'b0;
    for (int t = 0; t < 100 && busy_b; t++) @(negedge clk);
    check("decim drains", busy_b, 0);

    // kept sample on the edge where busy would fall is taken
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int k = 1; k <= 23; k++) begin
      sv_b = (k <= 4 || k >= 20) ? 1'b1 : 1'b0;
      @(negedge clk);
      if (k == 22) begin
        check("b2b advance busy", busy_b, 1);
        check("b2b advance req", b_if.wr_req, 0);
      end
    end
    sv_b = 1'b0;
    check("b2b busy", busy_b, 1);
    check("b2b req", b_if.wr_req, 1);
    check("b2b wr_y", b_if.wr_y, 0);
    check("b2b wr_x", b_if.wr_x, 1);
    check("b2b xcoord", vx_b, 1);
    check("b2b overrun", ovr_b, 0);
    for (int t = 0; t < 100 && busy_b; t++) @(negedge clk);
    check("b2b drains", busy_b, 0);
    check("b2b xcoord_end", vx_b, 2);

    // frame wrap over 640 columns
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    wraps = 0; wrap_col = -1; to_bad = 0; vx_pre = '0;
    for (int c = 0; c < 640; c++) begin
      int t;
      sv_b = 1'b1;
      repeat (4) @(negedge clk);
      sv_b = 1'b0;
      for (t = 0; t < 200; t++) begin
        if (fw_b) begin wraps++; wrap_col = c; end
        if (!busy_b) break;
        @(negedge clk);
      end
      if (t == 200) to_bad++;
      if (c == 638) vx_pre = vx_b;
    end
    check("wrap xcoord_639", vx_pre, 639);
    check("wrap pulses", wraps, 1);
    check("wrap column", wrap_col, 639);
    check("wrap xcoord_end", vx_b, 0);
    check("wrap timeouts", to_bad, 0);
    @(negedge clk);
    check("wrap pulse_width", fw_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trace_plotter.md
# trace_plotter

Downstream consumer of the `eulersillator` coupled-oscillator integrator. It decimates the per-step position stream (`x1`, `x2`, signed 2.16 fixed point) and converts each kept sample into screen coordinates for two scrolling traces. For each kept sample it writes one VGA column through a request/acknowledge pixel-write port: it erases the column, plots both traces, then advances the column. It sits between the integrator and the VGA frame-buffer arbiter.

## Interface
- `H_RES`, 640, columns per frame
- `V_RES`, 480, rows per column
- `DECIM`, 64, integrator steps per plotted column (≥1)
- `SCALE_LOG2`, 7, pixels per unit of x = 2^SCALE_LOG2 (0..16)
- `Y1_CENTER`, 120, screen row for x1 = 0
- `Y2_CENTER`, 360, screen row for x2 = 0
- `COLOR1`, 8'hE0, x1 trace colour
- `COLOR2`, 8'h1C, x2 trace colour
- `BG`, 8'h00, erase colour

Ports:
- `CLOCK_50`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low
- `sample_valid`  in  1  one-cycle strobe, one integrator step completed
- `x1`, `x2`  in  18 each  signed 2.16 positions, valid while `sample_valid` is high
- `wr_req`  out  1  pixel write request
- `wr_x`  out  10  write column
- `wr_y`  out  9  write row
- `wr_data`  out  8  write colour
- `wr_ack`  in  1  arbiter accepts the presented write this cycle
- `vga_xCoord`  out  10  current plot column
- `busy`  out  1  column write in progress
- `overrun`  out  1  sticky, a kept sample was dropped
- `frame_wrap`  out  1  one-cycle pulse on column wrap

## Operation
- **Decimation counter.** `dcnt` increments on every `sample_valid`, whether or not `busy` is high. When `sample_valid` arrives with `dcnt == DECIM-1`, the sample is kept and `dcnt` returns to 0.
  - Kept sample while idle: latch `x1` and `x2`, then enter CLEAR.
  - Kept sample while `busy`: discard it and set `overrun`. `overrun` clears only on reset.
- **Row mapping**, per trace:
  - `off = x >>> (16-SCALE_LOG2)`, arithmetic shift.
  - `y = CENTER - off`, computed 20-bit signed.
  - Clamp to [0, V_RES-1].
  - Compute once at capture and register.
- **FSM:** IDLE → CLEAR → PLOT1 → PLOT2 → ADVANCE → IDLE.
  - CLEAR: writes `BG` at `(vga_xCoord, r)` for r = 0..V_RES-1 in ascending order. It advances to the next row only on `wr_ack`.
  - PLOT1: writes `COLOR1` at `y1`.
  - PLOT2: writes `COLOR2` at `y2`. If `y1 == y2`, COLOR2 is last written and wins.
  - ADVANCE: no write. `vga_xCoord` increments; at H_RES-1 it wraps to 0 and pulses `frame_wrap`.
- **Write handshake.**
  - `wr_req`, `wr_x`, `wr_y` and `wr_data` stay stable until `wr_ack` is sampled high.
  - The next write may be presented the following cycle, with `wr_req` held high.
  - `wr_ack` with `wr_req` low is ignored.
  - The block never withdraws a pending request except on reset.
- `busy` is high in every state except IDLE.

## Timing
- **Reset** (asynchronous, immediate): all outputs 0 (`wr_req`, `wr_x`, `wr_y`, `wr_data`, `vga_xCoord`, `busy`, `overrun`, `frame_wrap`); FSM in IDLE; `dcnt` 0. Reset mid-column abandons the column; no partial state survives.
- **Capture at edge T:** `busy` and `wr_req` go high after T, with `wr_y = 0`.
- **Column latency with `wr_ack` tied high:**
  - V_RES + 2 write cycles, then ADVANCE.
  - `busy` falls V_RES + 3 cycles after T.
  - `vga_xCoord` updates on that same edge.
- **Stalled acknowledge:** each cycle of `wr_ack` low lengthens the column by one cycle.
- **Minimum `DECIM`:** a kept sample arriving on the same edge that `busy` falls is accepted (state is IDLE-bound). Worst case is 1 cycle of gap; `DECIM * step period ≥ V_RES + 3` avoids overrun.

## Test plan
- **Basic column:** `DECIM=1`, `wr_ack=1`, `x1=18'h3_8000` (-0.5), `x2=18'h0_8000` (+0.5).
  - 480 BG writes at column 0, then (0,184,COLOR1), then (0,296,COLOR2).
  - `vga_xCoord` becomes 1 at cycle T+483.
- **Clamp:** `x1=18'h1_FFFF`, `x2=18'h2_0000` (-2.0).
  - `y1` clamps to 0; `y2 = 360+256` clamps to 479.
- **Decimation and overrun:** `DECIM=4`, `sample_valid` every cycle.
  - Only every 4th sample captured.
  - Captures during `busy` are dropped; `overrun` rises after the first drop and stays high.
- **Handshake stall:** random `wr_ack` (50%).
  - Address and data are stable while `wr_req` is high and not acknowledged.
  - Write sequence is identical to the first scenario; no write lost or duplicated.
- **Wrap:** run 640 columns.
  - `frame_wrap` pulses exactly once, on the 640th ADVANCE; `vga_xCoord` returns to 0.
- **Reset mid-CLEAR:** pull `reset` low at row 200.
  - `wr_req` and `busy` go to 0 asynchronously, `vga_xCoord` to 0.
  - After release, the next kept sample starts a fresh CLEAR at row 0.
